// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch
//               front-end: queue depth, halfword PC type, queue entry
//               layout, ROM bank-select encodings and a consume clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Queue depth in halfword entries (power of two).
    localparam int QDEPTH = 4;

    // Halfword program counter.
    typedef logic [14:0] hpc_t;

    // One queue slot: the instruction halfword and the address it came from.
    typedef struct packed {
        logic [15:0] instr;
        hpc_t        pc;
    } qentry_t;

    // IR_0 bank-select encodings. SEL0_IR1 is reserved and never driven.
    localparam logic [1:0] SEL0_DATA0 = 2'd0;
    localparam logic [1:0] SEL0_IR1   = 2'd1;
    localparam logic [1:0] SEL0_DATA1 = 2'd2;

    // Decode may not take more instructions than are on offer.
    function automatic logic [1:0] clamp_consume(input logic [1:0] req,
                                                 input logic [1:0] avail);
        return (req > avail) ? avail : req;
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular halfword buffer. Accepts a pair of writes and up to
//               two reads per cycle; flush empties it and rewinds pointers.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flush_i         - discard contents, pointers back to 0
//               wr_en_i         - write wr_data0_i / wr_data1_i this cycle
//               wr_data0_i/1_i  - entries for wr_ptr and wr_ptr+1
//               rd_cnt_i        - entries retired this cycle (0..2)
//               count_o         - number of occupied entries
//               rd_data0_o/1_o  - entries at rd_ptr and rd_ptr+1 (raw)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  qentry_t                      wr_data0_i,
    input  qentry_t                      wr_data1_i,
    input  logic [1:0]                   rd_cnt_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output qentry_t                      rd_data0_o,
    output qentry_t                      rd_data1_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    qentry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic [PTR_W-1:0]   wr_ptr_p1;
    logic [PTR_W-1:0]   rd_ptr_p1;
    logic [CNT_W-1:0]   count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

    assign count_d = count_q - CNT_W'(rd_cnt_i) + (wr_en_i ? CNT_W'(2) : CNT_W'(0));

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(rd_cnt_i);
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(2);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: consumers gate the read data with count_o.
    always_ff @(posedge clk) begin
        if (wr_en_i && !rst && !flush_i) begin
            mem_q[wr_ptr_q]  <= wr_data0_i;
            mem_q[wr_ptr_p1] <= wr_data1_i;
        end
    end

    assign count_o    = count_q;
    assign rd_data0_o = mem_q[rd_ptr_q];
    assign rd_data1_o = mem_q[rd_ptr_p1];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front-end for the dual-issue Thumb core.
//               Drives the dual-bank ROM address/selects, buffers returned
//               halfwords in a small queue and presents up to two in-order
//               instructions per cycle to decode. Branches flush and redirect.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               Rom_addr, pc_1        - ROM word address / bank-0 increment
//               sel_mem_1, sel_mem_0  - IR_1 / IR_0 bank selects
//               IR_0, IR_1            - halfwords at fetch_pc, fetch_pc+1
//               inst_0, inst_1        - queue head and head+1 (0 if absent)
//               inst_0_pc             - halfword address of inst_0
//               inst_cnt              - valid instructions presented (0..2)
//               consume               - instructions taken by decode
//               branch_valid/_target  - redirect request and address
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          QDEPTH   = fetch_pkg::QDEPTH,
    parameter logic [14:0] RESET_PC = 15'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [13:0] Rom_addr,
    output logic        pc_1,
    output logic        sel_mem_1,
    output logic [1:0]  sel_mem_0,
    input  logic [15:0] IR_0,
    input  logic [15:0] IR_1,
    output logic [15:0] inst_0,
    output logic [15:0] inst_1,
    output logic [14:0] inst_0_pc,
    output logic [1:0]  inst_cnt,
    input  logic [1:0]  consume,
    input  logic        branch_valid,
    input  logic [14:0] branch_target
);

    localparam int CNT_W = $clog2(QDEPTH+1);

    hpc_t             fetch_pc_q;
    hpc_t             fetch_pc_d;
    logic [CNT_W-1:0] count;
    logic [1:0]       consume_eff;
    logic [1:0]       rd_cnt;
    logic             fetch_en;
    qentry_t          wr_data0;
    qentry_t          wr_data1;
    qentry_t          rd_data0;
    qentry_t          rd_data1;

    // ---------------------------------------------------------------- decode
    assign inst_cnt    = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
    assign consume_eff = clamp_consume(consume, inst_cnt);

    // Fetch only when a full pair is guaranteed to fit after this cycle's
    // retirement; a branch suppresses fetch of the now-stale stream.
    assign fetch_en = !branch_valid &&
                      ((count - CNT_W'(consume_eff)) <= CNT_W'(QDEPTH-2));

    // The consume presented alongside a branch is discarded with the flush.
    assign rd_cnt = branch_valid ? 2'd0 : consume_eff;

    assign wr_data0 = '{instr: IR_0, pc: fetch_pc_q};
    assign wr_data1 = '{instr: IR_1, pc: fetch_pc_q + 15'd1};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (branch_valid) begin
            fetch_pc_d = branch_target;
        end else if (fetch_en) begin
            fetch_pc_d = fetch_pc_q + 15'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // ------------------------------------------------------------ ROM drive
    // Even PC: bank 0 holds fetch_pc, bank 1 holds fetch_pc+1.
    // Odd PC : bank 1 holds fetch_pc, bank 0 (at word+1) holds fetch_pc+1.
    assign Rom_addr  = fetch_pc_q[14:1];
    assign pc_1      = fetch_pc_q[0];
    assign sel_mem_1 = !fetch_pc_q[0];
    assign sel_mem_0 = fetch_pc_q[0] ? SEL0_DATA1 : SEL0_DATA0;

    // ---------------------------------------------------------------- queue
    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (branch_valid),
        .wr_en_i    (fetch_en),
        .wr_data0_i (wr_data0),
        .wr_data1_i (wr_data1),
        .rd_cnt_i   (rd_cnt),
        .count_o    (count),
        .rd_data0_o (rd_data0),
        .rd_data1_o (rd_data1)
    );

    // ---------------------------------------------------------- presentation
    assign inst_0    = (count >= CNT_W'(1)) ? rd_data0.instr : 16'h0;
    assign inst_0_pc = (count >= CNT_W'(1)) ? rd_data0.pc    : 15'h0;
    assign inst_1    = (count >= CNT_W'(2)) ? rd_data1.instr : 16'h0;

    // Decode must never claim more than it was offered.
    a_consume_bound : assert property (
        @(posedge clk) disable iff (rst || branch_valid) consume <= inst_cnt
    );

endmodule : fetch_unit
`default_nettype wire
